ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_write input 1, cmd_addr input ADDR_W, cmd_wdata input DATA_W; this is the command request channel.
REQ-005 SHALL have ports rsp_valid output 1, rsp_rdata output DATA_W, rsp_err output 1; this is the completion channel, with no backpressure.
REQ-006 SHALL have AHB-Lite ports HADDR output ADDR_W, HTRANS output 2, HWRITE output 1, HSIZE output 3, HWDATA output DATA_W.
REQ-007 SHALL have AHB-Lite ports HRDATA input DATA_W, HREADY input 1, HRESP input 1.

Function
REQ-008 SHALL issue single word transfers only: HSIZE = 3'b010, HTRANS in {IDLE=2'b00, NONSEQ=2'b10}; BUSY and SEQ never driven.
REQ-009 SHALL word-align addresses: HADDR = {cmd_addr[ADDR_W-1:2], 2'b00}; cmd_addr[1:0] is ignored.
REQ-010 SHALL hold an address-phase register (ap: valid, addr, write, wdata) and a data-phase register (dp: valid, write, wdata).
REQ-011 SHALL drive HTRANS = NONSEQ, HADDR = ap.addr, HWRITE = ap.write while ap.valid; otherwise HTRANS = IDLE with HADDR and HWRITE held at their last values.
REQ-012 SHALL drive HWDATA = dp.wdata while dp.valid and dp.write; otherwise HWDATA holds its last value.
REQ-013 SHALL assert cmd_ready = !ap.valid || HREADY; accept a command on cmd_valid && cmd_ready.
REQ-014 SHALL use FSM states IDLE (no ap, no dp), ADDR (ap only), DATA (dp only), ADDR_DATA (both), encoded in the shared package.
REQ-015 SHALL, at a clock edge with HREADY=1: retire dp if valid; move ap to dp (dp.wdata = ap.wdata); load ap from an accepted command, or clear ap.
REQ-016 SHALL, at a clock edge with HREADY=0: hold ap and dp unchanged; if ap is empty and a command is accepted, load ap (IDLE->NONSEQ change during a wait state is permitted).
REQ-017 SHALL give back-to-back throughput of one transfer per cycle with zero-wait responder: command N+1 address phase overlaps command N data phase.
REQ-018 SHALL pulse rsp_valid for exactly one cycle, in the cycle after the edge at which dp retires with HREADY=1.
REQ-019 SHALL set rsp_rdata = HRDATA sampled at retirement for reads and 0 for writes, with rsp_err = HRESP sampled at retirement.
REQ-020 SHALL, on an ERROR response (HRESP=1, HREADY=0 then HRESP=1, HREADY=1), complete the transfer with rsp_err=1 and SHALL NOT cancel a pending address phase; the following transfer proceeds normally.
REQ-021 SHALL, when cmd_valid is held with cmd_ready=0, leave HADDR, HTRANS and HWRITE stable until HREADY=1.
REQ-022 SHALL keep latency from command accept to rsp_valid at 2 cycles plus the wait states of its data phase.

Reset
REQ-023 SHALL, on reset assertion, immediately clear ap.valid and dp.valid and set the state to IDLE.
REQ-024 SHALL drive these reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, HSIZE=3'b010, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-025 SHALL, on reset mid-transfer, discard in-flight transfers with no rsp_valid; cmd_ready SHALL be 1 from the first cycle after deassertion.

Structure
REQ-026 SHALL place in shared package ahb_pkg: htrans_t enum (IDLE, BUSY, NONSEQ, SEQ), HSIZE_WORD = 3'b010, and master_state_t (IDLE, ADDR, DATA, ADDR_DATA).
REQ-027 SHALL be a single module with no sub-module; the responder model and address decoder live in the testbench/top.

Verification
REQ-028 SHALL cover single read: responder preloaded with 0x11223344 at 0x00, zero-wait; read 0x00 -> HTRANS=NONSEQ for 1 cycle, rsp_valid 2 cycles after accept, rsp_rdata=0x11223344, rsp_err=0.
REQ-029 SHALL cover write then readback: write 0xCAFEBA0E to 0x0C, then read 0x0C -> second rsp_rdata=0xCAFEBA0E, and HWDATA=0xCAFEBA0E during the write data phase.
REQ-030 SHALL cover pipelined burst: 4 back-to-back reads at 0x00/0x04/0x08/0x0C, zero-wait -> HTRANS=NONSEQ for 4 consecutive cycles, 4 consecutive rsp_valid pulses (0x11223344, 0x55667788, 0xDAADBECF, 0xCAFEBA0E).
REQ-031 SHALL cover wait states: HREADY low 3 cycles during the data phase of a read at 0x10 (0x12345678) -> HADDR/HTRANS of the next command stable throughout, cmd_ready=0, rsp arrives 3 cycles late with the correct data.
REQ-032 SHALL cover error: two-cycle ERROR on a write to 0x400 with a read of 0x04 pending -> rsp_err=1 for the write, then the read completes with 0x55667788, rsp_err=0.
REQ-033 SHALL cover reset mid-operation: reset asserted during an ADDR_DATA state -> HTRANS=IDLE immediately, no rsp_valid, and a new read accepted on the first cycle after release.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the master and anything that talks to it.
//   htrans_t       : HTRANS transfer-type encoding
//   HSIZE_WORD     : HSIZE value for 32-bit single transfers
//   master_state_t : pipeline occupancy of the master (address / data phase)
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,       // no address phase, no data phase
    ST_ADDR,       // address phase only
    ST_DATA,       // data phase only
    ST_ADDR_DATA   // both phases occupied
  } master_state_t;

  function automatic master_state_t state_of(input logic ap_v, input logic dp_v);
    case ({ap_v, dp_v})
      2'b10:   return ST_ADDR;
      2'b01:   return ST_DATA;
      2'b11:   return ST_ADDR_DATA;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-word master with a two-stage (address/data) pipeline.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata: command request channel
//   rsp_valid/rdata/err             : completion channel, one-cycle pulse, no backpressure
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA: AHB-Lite master outputs
//   HRDATA/HREADY/HRESP             : AHB-Lite responder inputs
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  master_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic              ap_write_q, ap_write_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic ap_valid, dp_valid, accept, ap_valid_nx, dp_valid_nx;
  logic unused_cmd_addr_lo;

  // Byte offset is ignored: all transfers are word-aligned.
  assign unused_cmd_addr_lo = ^cmd_addr[1:0];

  assign ap_valid  = (state_q == ST_ADDR) || (state_q == ST_ADDR_DATA);
  assign dp_valid  = (state_q == ST_DATA) || (state_q == ST_ADDR_DATA);
  assign cmd_ready = !ap_valid || HREADY;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_wdata_d  = ap_wdata_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ap_valid_nx = ap_valid;
    dp_valid_nx = dp_valid;

    if (HREADY) begin
      if (dp_valid) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = dp_write_q ? '0 : HRDATA;
        rsp_err_d   = HRESP;
      end
      dp_valid_nx = ap_valid;
      if (ap_valid) begin
        dp_write_d = ap_write_q;
        // dp wdata only moves for writes so HWDATA keeps its last write value.
        if (ap_write_q) dp_wdata_d = ap_wdata_q;
      end
      ap_valid_nx = accept;
    end else begin
      // Wait state: both phases frozen; an empty ap may still take a command.
      ap_valid_nx = ap_valid || accept;
    end

    if (accept) begin
      ap_addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
      ap_write_d = cmd_write;
      ap_wdata_d = cmd_wdata;
    end

    state_d = state_of(ap_valid_nx, dp_valid_nx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_wdata_q  <= '0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ap_addr/ap_write only change on accept, so they already hold their
  // last values whenever the address phase is empty.
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HTRANS    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master with a pipelined
// word-addressed responder model (per-address wait/error injection).
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize;

  always #5 clk = ~clk;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
  );

  // ---------------- responder model ----------------
  logic [31:0] mem [512];
  logic        ph_valid, ph_write, ph_err;
  logic [31:0] ph_addr;
  int unsigned wait_left;
  logic [31:0] knob_addr  = 32'hFFFF_FFFC;
  int unsigned knob_waits = 0;
  logic        knob_err   = 1'b0;

  assign hready = !ph_valid || (wait_left == 0);
  assign hresp  = ph_valid && ph_err;
  assign hrdata = (ph_valid && !ph_write) ? mem[ph_addr[10:2]] : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_valid  <= 1'b0;
      ph_write  <= 1'b0;
      ph_err    <= 1'b0;
      ph_addr   <= 32'h0;
      wait_left <= 0;
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[1] <= 32'h5566_7788;
      mem[2] <= 32'hDAAD_BECF;
      mem[4] <= 32'h1234_5678;
    end else if (ph_valid && wait_left != 0) begin
      wait_left <= wait_left - 1;
    end else begin
      if (ph_valid && ph_write && !ph_err) mem[ph_addr[10:2]] <= hwdata;
      ph_valid <= 1'b0;
      if (htrans == 2'b10) begin
        ph_valid  <= 1'b1;
        ph_addr   <= haddr;
        ph_write  <= hwrite;
        wait_left <= (haddr == knob_addr) ? knob_waits : 0;
        ph_err    <= (haddr == knob_addr) ? knob_err : 1'b0;
      end
    end
  end

  // ---------------- cycle counter and response capture ----------------
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rb_data [64];
  logic        rb_err  [64];
  int unsigned rb_cyc  [64];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;

  always @(negedge clk) begin
    if (rsp_valid && wr_idx < 64) begin
      rb_data[wr_idx] <= rsp_rdata;
      rb_err[wr_idx]  <= rsp_err;
      rb_cyc[wr_idx]  <= cyc;
      wr_idx          <= wr_idx + 1;
    end
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  // Presents a command until accepted; returns cyc seen after the accept edge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output int unsigned acc);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1; ok = cmd_ready;
      @(posedge clk);
      @(negedge clk); #1;
    end
    acc = cyc;
    check_eq("accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic drop();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int unsigned c);
    logic got;
    got = 1'b0; d = 32'h0; e = 1'b0; c = 0;
    #1;
    for (int i = 0; i < 30 && !got; i++) begin
      if (rd_idx != wr_idx) begin
        d = rb_data[rd_idx]; e = rb_err[rd_idx]; c = rb_cyc[rd_idx];
        rd_idx++;
        got = 1'b1;
      end else begin
        @(negedge clk); #1;
      end
    end
    check_eq("rsp_arrived", {31'b0, got}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned a0, a1, a2, a3, rc, rel;
    int unsigned acc [4];
    logic [31:0] rd;
    logic        re;
    logic [31:0] burst_addr [4];
    logic [31:0] burst_data [4];
    burst_addr = '{32'h00, 32'h04, 32'h08, 32'h0C};
    burst_data = '{32'h1122_3344, 32'h5566_7788, 32'hDAAD_BECF, 32'hCAFE_BA0E};

    reset = 1'b1;
    drop();
    #2;
    check_eq("rst_htrans", {30'b0, htrans}, 32'd0);
    check_eq("rst_haddr", haddr, 32'h0);
    check_eq("rst_hwrite", {31'b0, hwrite}, 32'd0);
    check_eq("rst_hwdata", hwdata, 32'h0);
    check_eq("rst_hsize", {29'b0, hsize}, 32'd2);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // single read
    send(1'b0, 32'h00, 32'h0, a0);
    check_eq("rd1_htrans", {30'b0, htrans}, 32'd2);
    check_eq("rd1_haddr", haddr, 32'h00);
    check_eq("rd1_hwrite", {31'b0, hwrite}, 32'd0);
    drop();
    sync();
    check_eq("rd1_htrans_idle", {30'b0, htrans}, 32'd0);
    wait_rsp(rd, re, rc);
    check_eq("rd1_data", rd, 32'h1122_3344);
    check_eq("rd1_err", {31'b0, re}, 32'd0);
    check_eq("rd1_latency", rc - a0, 32'd2);

    // write then readback
    sync();
    send(1'b1, 32'h0C, 32'hCAFE_BA0E, a0);
    check_eq("wr_hwrite", {31'b0, hwrite}, 32'd1);
    check_eq("wr_haddr", haddr, 32'h0C);
    send(1'b0, 32'h0C, 32'h0, a1);
    check_eq("wr_hwdata", hwdata, 32'hCAFE_BA0E);
    check_eq("rb_hwrite", {31'b0, hwrite}, 32'd0);
    drop();
    wait_rsp(rd, re, rc);
    check_eq("wr_rsp_rdata", rd, 32'h0);
    check_eq("wr_latency", rc - a0, 32'd2);
    wait_rsp(rd, re, rc);
    check_eq("rb_data", rd, 32'hCAFE_BA0E);
    check_eq("rb_latency", rc - a1, 32'd2);

    // pipelined burst of 4 reads
    sync();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, burst_addr[i], 32'h0, acc[i]);
      check_eq("burst_htrans", {30'b0, htrans}, 32'd2);
      check_eq("burst_haddr", haddr, burst_addr[i]);
    end
    drop();
    for (int i = 0; i < 4; i++) begin
      wait_rsp(rd, re, rc);
      check_eq("burst_data", rd, burst_data[i]);
      check_eq("burst_cycle", rc - acc[0], 32'd2 + i);
    end

    // wait states on read 0x10 with next commands queued
    sync();
    knob_addr = 32'h10; knob_waits = 3; knob_err = 1'b0;
    send(1'b0, 32'h10, 32'h0, a0);
    send(1'b0, 32'h00, 32'h0, a1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h07;
    for (int i = 0; i < 3; i++) begin
      check_eq("ws_hready", {31'b0, hready}, 32'd0);
      check_eq("ws_haddr", haddr, 32'h00);
      check_eq("ws_htrans", {30'b0, htrans}, 32'd2);
      check_eq("ws_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      if (i < 2) sync();
    end
    send(1'b0, 32'h07, 32'h0, a2);
    check_eq("ws_align_haddr", haddr, 32'h04);
    drop();
    wait_rsp(rd, re, rc);
    check_eq("ws_data", rd, 32'h1234_5678);
    check_eq("ws_latency", rc - a0, 32'd5);
    wait_rsp(rd, re, rc);
    check_eq("ws_next_data", rd, 32'h1122_3344);
    wait_rsp(rd, re, rc);
    check_eq("ws_third_data", rd, 32'h5566_7788);
    check_eq("ws_third_latency", rc - a2, 32'd2);

    // error response on write 0x400 with read 0x04 pending
    sync();
    knob_addr = 32'h400; knob_waits = 1; knob_err = 1'b1;
    send(1'b1, 32'h400, 32'hDEAD_0001, a0);
    send(1'b0, 32'h04, 32'h0, a1);
    drop();
    check_eq("err_hresp_1st", {31'b0, hresp}, 32'd1);
    check_eq("err_hready_1st", {31'b0, hready}, 32'd0);
    check_eq("err_pend_htrans", {30'b0, htrans}, 32'd2);
    check_eq("err_pend_haddr", haddr, 32'h04);
    sync();
    check_eq("err_pend_htrans2", {30'b0, htrans}, 32'd2);
    wait_rsp(rd, re, rc);
    check_eq("err_rsp_err", {31'b0, re}, 32'd1);
    check_eq("err_rsp_rdata", rd, 32'h0);
    wait_rsp(rd, re, rc);
    check_eq("err_next_data", rd, 32'h5566_7788);
    check_eq("err_next_err", {31'b0, re}, 32'd0);
    knob_addr = 32'hFFFF_FFFC; knob_waits = 0; knob_err = 1'b0;

    // reset in ADDR_DATA
    sync();
    send(1'b0, 32'h08, 32'h0, a0);
    send(1'b0, 32'h0C, 32'h0, a1);
    drop();
    reset = 1'b1;
    #1;
    check_eq("rstmid_htrans", {30'b0, htrans}, 32'd0);
    check_eq("rstmid_haddr", haddr, 32'h0);
    check_eq("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    rel = cyc;
    check_eq("rstmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_eq("rstmid_no_rsp", wr_idx - rd_idx, 32'd0);
    send(1'b0, 32'h08, 32'h0, a3);
    check_eq("rstmid_accept_cycle", a3 - rel, 32'd1);
    drop();
    wait_rsp(rd, re, rc);
    check_eq("rstmid_data", rd, 32'hDAAD_BECF);
    check_eq("rstmid_latency", rc - a3, 32'd2);

    repeat (5) sync();
    check_eq("no_extra_rsp", wr_idx - rd_idx, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
